// File: rtl/treino_pkg.sv
// treino_pkg: shared definitions for the training-run controller.
//   - default parameter values for treino_ctrl
//   - FP16 (IEEE 754 half) constants used by the datapath and the bench
//   - FSM state encoding
package treino_pkg;

  localparam int DEF_TAM        = 16;
  localparam int DEF_MAX_EPOCAS = 32;
  localparam int DEF_TIMEOUT    = 64;

  localparam logic [15:0] FP_ONE     = 16'h3C00;
  localparam logic [15:0] FP_ZERO    = 16'h0000;
  localparam logic [15:0] FP_NEG_ONE = 16'hBC00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_CHECK,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/treino_ctrl_conv_check.sv
// conv_check: combinational convergence test. Asserts match_o when all four
// TAM-bit result rows are bitwise equal to the corresponding target rows.
// Ports:
//   result_i  4xTAM  per-row results (row r at [r*TAM +: TAM])
//   target_i  4xTAM  per-row targets, same layout
//   match_o   1      all rows equal
module conv_check
  import treino_pkg::*;
#(
  parameter int TAM = DEF_TAM
) (
  input  logic [4*TAM-1:0] result_i,
  input  logic [4*TAM-1:0] target_i,
  output logic             match_o
);

  logic [3:0] row_eq;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign row_eq[r] = (result_i[r*TAM +: TAM] == target_i[r*TAM +: TAM]);
  end

  assign match_o = &row_eq;

endmodule

// File: rtl/treino_ctrl.sv
// treino_ctrl: sequences a training run. Loads initial weights, launches one
// epoch at a time on the downstream epoch stage, absorbs the updated weights
// and results, and stops on the epoch limit, a wait timeout, or (optionally)
// convergence.
// Build option: TREINO_EARLY_STOP_EN -- when defined, a converged epoch ends
// the run at once; otherwise the run always goes to MAX_EPOCAS epochs.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                run request (IDLE only)
//   w0/w1/w2_init, d     initial weights, per-row targets (4xTAM)
//   ep_start             one-cycle epoch launch pulse
//   ep_done, ep_w*,      epoch completion strobe, updated weights and
//   ep_result            per-row results (4xTAM), taken in WAIT only
//   w0/w1/w2             registered current weights
//   busy, done           not-IDLE, one-cycle end-of-run pulse
//   converged, err       targets matched, epoch stage timed out
//   epoch_count          epochs completed this run
module treino_ctrl
  import treino_pkg::*;
#(
  parameter int TAM        = DEF_TAM,
  parameter int MAX_EPOCAS = DEF_MAX_EPOCAS,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [TAM-1:0]   w0_init,
  input  logic [TAM-1:0]   w1_init,
  input  logic [TAM-1:0]   w2_init,
  input  logic [4*TAM-1:0] d,
  output logic             ep_start,
  input  logic             ep_done,
  input  logic [TAM-1:0]   ep_w0,
  input  logic [TAM-1:0]   ep_w1,
  input  logic [TAM-1:0]   ep_w2,
  input  logic [4*TAM-1:0] ep_result,
  output logic [TAM-1:0]   w0,
  output logic [TAM-1:0]   w1,
  output logic [TAM-1:0]   w2,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic             err,
  output logic [7:0]       epoch_count
);

  localparam int             WCW       = $clog2(TIMEOUT + 1);
  // Last WAIT cycle index: TIMEOUT cycles in WAIT without ep_done is a timeout.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [7:0]     EP_MAX    = 8'(MAX_EPOCAS);

  state_t             state_q, state_d;
  logic [TAM-1:0]     w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [4*TAM-1:0]   res_q, res_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [7:0]         epc_q, epc_d;
  logic               conv_q, conv_d, err_q, err_d;
  logic               match;

  conv_check #(.TAM(TAM)) u_conv (
    .result_i (res_q),
    .target_i (d),
    .match_o  (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      res_q   <= '0;
      wcnt_q  <= '0;
      epc_q   <= '0;
      conv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      res_q   <= res_d;
      wcnt_q  <= wcnt_d;
      epc_q   <= epc_d;
      conv_q  <= conv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    res_d   = res_q;
    wcnt_d  = wcnt_q;
    epc_d   = epc_q;
    conv_d  = conv_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          conv_d  = 1'b0;
          err_d   = 1'b0;
          epc_d   = '0;
        end
      end
      ST_LOAD: begin
        w0_d    = w0_init;
        w1_d    = w1_init;
        w2_d    = w2_init;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // ep_done wins over a coincident timeout.
        if (ep_done) begin
          w0_d    = ep_w0;
          w1_d    = ep_w1;
          w2_d    = ep_w2;
          res_d   = ep_result;
          if (epc_q != EP_MAX) epc_d = epc_q + 8'd1;
          state_d = ST_CHECK;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (match) conv_d = 1'b1;
`ifdef TREINO_EARLY_STOP_EN
        if (match || epc_q == EP_MAX) state_d = ST_FINISH;
        else                          state_d = ST_RUN;
`else
        if (epc_q == EP_MAX) state_d = ST_FINISH;
        else                 state_d = ST_RUN;
`endif
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign ep_start    = (state_q == ST_RUN);
  assign done        = (state_q == ST_FINISH);
  assign busy        = (state_q != ST_IDLE);
  assign w0          = w0_q;
  assign w1          = w1_q;
  assign w2          = w2_q;
  assign converged   = conv_q;
  assign err         = err_q;
  assign epoch_count = epc_q;

endmodule

// File: tb/tb_treino_ctrl.sv
module tb_treino_ctrl;
  import treino_pkg::*;

  localparam int TAM = 16;
  localparam int MAXE = 4;
  localparam int TMO = 64;

`ifdef TREINO_EARLY_STOP_EN
  localparam int CONV_EP = 1;
`else
  localparam int CONV_EP = MAXE;
`endif

  localparam int M_MATCH = 0, M_ADD = 1, M_SILENT = 2;

  logic clk = 1'b0;
  logic reset, start, ep_done, ep_start, busy, done, converged, err;
  logic [TAM-1:0] w0_init, w1_init, w2_init, ep_w0, ep_w1, ep_w2, w0, w1, w2;
  logic [4*TAM-1:0] d, ep_result;
  logic [7:0] epoch_count;

  treino_ctrl #(.TAM(TAM), .MAX_EPOCAS(MAXE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init), .d(d),
    .ep_start(ep_start), .ep_done(ep_done),
    .ep_w0(ep_w0), .ep_w1(ep_w1), .ep_w2(ep_w2), .ep_result(ep_result),
    .w0(w0), .w1(w1), .w2(w2), .busy(busy), .done(done),
    .converged(converged), .err(err), .epoch_count(epoch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n_ep;
    logic        conv;
    logic        err;
    logic [7:0]  epc;
    logic [15:0] w0, w1, w2;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int mode = M_SILENT;
  int glitch = 0;
  int add_idx = 0;
  logic [15:0] add_tab [4] = '{16'h3800, 16'h3C00, 16'h3E00, 16'h4000};
  logic [4*TAM-1:0] flip = 64'h8000_0000_0000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, want);
  endtask

  function automatic exp_t mk(int n, logic c, logic e, int epc,
                              logic [15:0] a, logic [15:0] b, logic [15:0] g, int lat);
    exp_t x;
    x.n_ep = n; x.conv = c; x.err = e; x.epc = 8'(epc);
    x.w0 = a; x.w1 = b; x.w2 = g; x.lat = lat;
    return x;
  endfunction

  // Epoch-stage model: answers in the first WAIT cycle after ep_start.
  int pend = 0;
  initial forever begin
    @(negedge clk);
    ep_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        ep_done = 1'b1;
        if (mode == M_ADD) begin
          ep_w0 = add_tab[add_idx % 4];
          add_idx++;
          ep_w1 = FP_NEG_ONE;
          ep_w2 = w2_init;
          ep_result = d ^ flip;
        end else begin
          ep_w0 = w0_init; ep_w1 = w1_init; ep_w2 = w2_init;
          ep_result = d;
        end
      end
    end
    if (ep_start) begin
      if (mode != M_SILENT) pend = 1;
      if (glitch != 0) begin
        ep_done = 1'b1;
        ep_w0 = 16'h7777;
        ep_result = d;
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  int cyc = 0, ep_run = 0, last_ep = 0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (reset) ep_run = 0;
    else begin
      if (ep_start) begin ep_run++; last_ep = cyc; end
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with nothing expected", cyc);
        end else begin
          e = sb.pop_front();
          chk("n_ep_start", 32'(ep_run), 32'(e.n_ep));
          chk("converged", {31'd0, converged}, {31'd0, e.conv});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("epoch_count", {24'd0, epoch_count}, {24'd0, e.epc});
          chk("w0", {16'd0, w0}, {16'd0, e.w0});
          chk("w1", {16'd0, w1}, {16'd0, e.w1});
          chk("w2", {16'd0, w2}, {16'd0, e.w2});
          chk("last_ep_to_done", 32'(cyc - last_ep), 32'(e.lat));
          chk("busy_in_finish", {31'd0, busy}, 32'd1);
        end
        ep_run = 0;
      end
    end
  end

  task automatic run(input int md, input logic [15:0] i0, i1, i2, input exp_t e, input int hold);
    bit seen = 0;
    mode = md; add_idx = 0;
    w0_init = i0; w1_init = i1; w2_init = i2;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    if (hold == 0) start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      n_chk++;
      $display("FAIL done_timeout: no done within 400 cycles");
      void'(sb.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_ep_start"}, {31'd0, ep_start}, 32'd0);
    chk({tag, "_conv"}, {31'd0, converged}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_epc"}, {24'd0, epoch_count}, 32'd0);
    chk({tag, "_w"}, {w0, w1}, 32'd0);
    chk({tag, "_w2"}, {16'd0, w2}, 32'd0);
  endtask

  initial begin
    int busy_seen;
    reset = 1'b1; start = 1'b0; ep_done = 1'b0;
    w0_init = '0; w1_init = '0; w2_init = '0;
    ep_w0 = '0; ep_w1 = '0; ep_w2 = '0;
    d = {FP_ONE, FP_ONE, FP_ONE, FP_ZERO};
    ep_result = '0;
    repeat (3) @(negedge clk);
    chk_idle_reset("reset");
    reset = 1'b0;
    @(negedge clk);

    // Timeout: stage never answers; 64 WAIT cycles then FINISH.
    run(M_SILENT, 16'h1234, 16'h5678, 16'h9ABC,
        mk(1, 1'b0, 1'b1, 0, 16'h1234, 16'h5678, 16'h9ABC, TMO + 1), 0);

    // Results equal targets every epoch.
    run(M_MATCH, FP_ONE, FP_ZERO, FP_NEG_ONE,
        mk(CONV_EP, 1'b1, 1'b0, CONV_EP, FP_ONE, FP_ZERO, FP_NEG_ONE, 3), 0);

    // Never matches (row 3 sign flipped); w0 steps 0.5 per epoch: 0 -> 2.0.
    run(M_ADD, FP_ZERO, FP_ZERO, FP_ONE,
        mk(MAXE, 1'b0, 1'b0, MAXE, 16'h4000, FP_NEG_ONE, FP_ONE, 3), 0);

    // start held through the run, stray ep_done during RUN.
    glitch = 1;
    run(M_MATCH, FP_NEG_ONE, FP_ONE, FP_ZERO,
        mk(CONV_EP, 1'b1, 1'b0, CONV_EP, FP_NEG_ONE, FP_ONE, FP_ZERO, 3), 1);
    glitch = 0;
    busy_seen = 0;
    repeat (5) begin @(negedge clk); if (busy) busy_seen++; end
    chk("no_restart", 32'(busy_seen), 32'd0);

    // Reset mid-WAIT, then a stale ep_done.
    mode = M_SILENT;
    w0_init = FP_ONE; w1_init = FP_NEG_ONE; w2_init = FP_ONE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_wait_busy", {31'd0, busy}, 32'd1);
    chk("mid_wait_w0", {16'd0, w0}, {16'd0, FP_ONE});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 ep_done = 1'b1;
    busy_seen = 0;
    repeat (10) begin @(negedge clk); if (busy || done) busy_seen++; end
    chk("abort_no_activity", 32'(busy_seen), 32'd0);
    chk_idle_reset("abort");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
